// File: rtl/mouse_dir_tracker.sv
// Motion/direction tracker for binned PS/2 mouse coordinates: signed deltas,
// 3x3 one-hot direction with dead zone and hold timer, button edges, event count.
module mouse_dir_tracker #(
  parameter int unsigned COORD_W     = 11,
  parameter int unsigned DEADZONE    = 1,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               PS2_CLK,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [2:0]         btn_in,
  output logic [8:0]         MS_DIR,
  output logic [COORD_W:0]   dx,
  output logic [COORD_W:0]   dy,
  output logic               dir_valid,
  output logic               moving,
  output logic [2:0]         btn_press,
  output logic [2:0]         btn_release,
  output logic [CNT_W-1:0]   motion_cnt
);

  localparam int unsigned DW     = COORD_W + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [8:0]  CENTRE = 9'b000010000;
  localparam logic signed [DW-1:0] DZ = DW'(DEADZONE);

  typedef enum logic [1:0] {UNPRIMED, STILL, MOVING} state_t;

  state_t             state, state_n;
  logic [COORD_W-1:0] prev_x, prev_x_n, prev_y, prev_y_n;
  logic [2:0]         prev_btn, prev_btn_n;
  logic [HOLD_W-1:0]  hold, hold_n;
  logic [8:0]         ms_dir_n;
  logic [DW-1:0]      dx_n, dy_n;
  logic               dir_valid_n, moving_n;
  logic [2:0]         press_n, release_n;
  logic [CNT_W-1:0]   cnt_n;

  logic signed [DW-1:0] delta_x_c, delta_y_c;
  logic [1:0]           col_c, row_c;
  logic [3:0]           idx_c;
  logic                 qualifying_c;
  logic [CNT_W-1:0]     cnt_inc_c;

  // Delta and 3x3 classification of the incoming sample
  always_comb begin
    delta_x_c = $signed({1'b0, x_in} - {1'b0, prev_x});
    delta_y_c = $signed({1'b0, y_in} - {1'b0, prev_y});
    col_c = (delta_x_c < -DZ) ? 2'd0 : (delta_x_c > DZ) ? 2'd2 : 2'd1;
    row_c = (delta_y_c < -DZ) ? 2'd0 : (delta_y_c > DZ) ? 2'd2 : 2'd1;
    idx_c = 4'(row_c) * 4'd3 + 4'(col_c);
    qualifying_c = (row_c != 2'd1) || (col_c != 2'd1);
    cnt_inc_c = (motion_cnt != {CNT_W{1'b1}}) ? motion_cnt + CNT_W'(1) : motion_cnt;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    prev_x_n    = prev_x;
    prev_y_n    = prev_y;
    prev_btn_n  = prev_btn;
    hold_n      = hold;
    ms_dir_n    = MS_DIR;
    dx_n        = dx;
    dy_n        = dy;
    dir_valid_n = 1'b0;
    press_n     = 3'b000;
    release_n   = 3'b000;
    cnt_n       = motion_cnt;

    if (sample_valid) begin
      prev_x_n   = x_in;
      prev_y_n   = y_in;
      prev_btn_n = btn_in;
    end

    case (state)
      UNPRIMED: begin
        if (sample_valid) state_n = STILL;
      end
      STILL: begin
        if (sample_valid && qualifying_c) begin
          ms_dir_n = 9'(1) << idx_c;
          hold_n   = HOLD_W'(HOLD_CYCLES);
          cnt_n    = cnt_inc_c;
          state_n  = MOVING;
        end
      end
      MOVING: begin
        if (sample_valid && qualifying_c) begin
          ms_dir_n = 9'(1) << idx_c;
          hold_n   = HOLD_W'(HOLD_CYCLES);
          cnt_n    = cnt_inc_c;
        end else if (hold <= HOLD_W'(1)) begin
          hold_n   = '0;
          ms_dir_n = CENTRE;
          state_n  = STILL;
        end else begin
          hold_n = hold - HOLD_W'(1);
        end
      end
      default: state_n = UNPRIMED;
    endcase

    // Deltas and button edges are reported for every primed sample
    if (sample_valid && state != UNPRIMED) begin
      dx_n        = delta_x_c;
      dy_n        = delta_y_c;
      dir_valid_n = 1'b1;
      press_n     = btn_in & ~prev_btn;
      release_n   = ~btn_in & prev_btn;
    end

    moving_n = (state_n == MOVING);
  end

  always_ff @(posedge PS2_CLK) begin
    if (reset) begin
      state       <= UNPRIMED;
      prev_x      <= '0;
      prev_y      <= '0;
      prev_btn    <= '0;
      hold        <= '0;
      MS_DIR      <= CENTRE;
      dx          <= '0;
      dy          <= '0;
      dir_valid   <= 1'b0;
      moving      <= 1'b0;
      btn_press   <= '0;
      btn_release <= '0;
      motion_cnt  <= '0;
    end else begin
      state       <= state_n;
      prev_x      <= prev_x_n;
      prev_y      <= prev_y_n;
      prev_btn    <= prev_btn_n;
      hold        <= hold_n;
      MS_DIR      <= ms_dir_n;
      dx          <= dx_n;
      dy          <= dy_n;
      dir_valid   <= dir_valid_n;
      moving      <= moving_n;
      btn_press   <= press_n;
      btn_release <= release_n;
      motion_cnt  <= cnt_n;
    end
  end

endmodule

// File: doc/mouse_dir_tracker.md
Name: mouse_dir_tracker

Overview:
Parametrised motion and direction tracker that sits after the PS/2 binning stage in the mouse path. It takes binned cursor coordinates and per-sample button levels, and computes registered signed deltas. It classifies each delta into a 3x3 one-hot direction (MS_DIR), with a dead zone and a hold timer so the downstream display sees stable directions. It also produces button press/release pulses and a saturating motion-event counter.

Parameters:
COORD_W, 11, width of x_in/y_in (unsigned bin coordinates)
DEADZONE, 1, |delta| <= DEADZONE on an axis is treated as no motion on that axis
HOLD_CYCLES, 8, PS2_CLK cycles a non-centre direction is held after the last qualifying motion sample (>=1)
CNT_W, 16, width of the motion-event counter

Ports:
PS2_CLK  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
sample_valid  in  1  x_in/y_in/buttons valid this cycle
x_in  in  COORD_W  binned x coordinate
y_in  in  COORD_W  binned y coordinate (grows downward)
btn_in  in  3  {middle,right,left} button levels
MS_DIR  out  9  one-hot direction, index = row*3+col
dx  out  COORD_W+1  signed x delta of last accepted sample
dy  out  COORD_W+1  signed y delta of last accepted sample
dir_valid  out  1  one-cycle pulse when MS_DIR/dx/dy updated from a sample
moving  out  1  high while state is MOVING
btn_press  out  3  one-cycle rising-edge pulses per button
btn_release  out  3  one-cycle falling-edge pulses per button
motion_cnt  out  CNT_W  count of qualifying motion samples, saturating

Behaviour:
- Reset is synchronous, active-high, on PS2_CLK. Reset values: MS_DIR=9'b000010000 (index 4, centre), dx=0, dy=0, dir_valid=0, moving=0, btn_press=0, btn_release=0, motion_cnt=0. Internally prev_x/prev_y=0, prev_btn=0, hold counter=0, state=UNPRIMED.
- Delta arithmetic: dx = {0,x_in} - {0,prev_x} in COORD_W+1 bits two's complement; dy likewise. No overflow is possible.
- Axis classification: col=0 if dx < -DEADZONE, col=2 if dx > DEADZONE, else col=1. Row=0 (up) if dy < -DEADZONE, row=2 (down) if dy > DEADZONE, else row=1. A sample is qualifying if (row,col) != (1,1).
- All outputs are registered. Every update occurs 1 cycle after the sample_valid cycle.
- States:
  - UNPRIMED: on sample_valid, load prev_x/prev_y/prev_btn and go to STILL. Outputs unchanged, dir_valid=0, no button pulses.
  - STILL: on a sample_valid that is not qualifying, update dx/dy, pulse dir_valid, keep MS_DIR centre, and stay. On a qualifying sample, update dx/dy, set MS_DIR to one-hot(row*3+col), pulse dir_valid, load hold=HOLD_CYCLES, increment motion_cnt, and go to MOVING.
  - MOVING: on a qualifying sample, update MS_DIR/dx/dy, pulse dir_valid, reload hold=HOLD_CYCLES (the reload wins over the decrement in the same cycle), and increment motion_cnt. On a non-qualifying sample, update dx/dy and pulse dir_valid, but keep MS_DIR and do not reload. In any cycle without a reload, hold decrements. When hold reaches 0, MS_DIR returns to centre and the state goes to STILL. moving=1 throughout MOVING.
- prev_x/prev_y are updated on every sample_valid in STILL and MOVING.
- Buttons: on each sample_valid in STILL or MOVING, btn_press = btn_in & ~prev_btn and btn_release = ~btn_in & prev_btn, then prev_btn <= btn_in. Pulses last exactly 1 cycle and are independent of motion.
- motion_cnt saturates at all-ones. It does not wrap.
- Without sample_valid, only the hold timer advances. All pulse outputs are 0.
- Reset asserted mid-MOVING returns everything to reset values on the next edge. The first sample after reset is a priming sample only.

Test Plan:
- Reset, then sample (100,100) -> no dir_valid, MS_DIR=index4. Then sample (110,100) -> 1 cycle later dx=+10, dy=0, MS_DIR[5]=1, dir_valid=1, moving=1, motion_cnt=1.
- Dead zone, DEADZONE=1: samples (50,50),(51,49) -> MS_DIR stays index4, dir_valid=1, dx=+1, dy=-1, motion_cnt=0.
- Hold expiry, HOLD_CYCLES=8: qualifying sample (0,0)->(0,20) gives MS_DIR[7] (down), followed by no samples -> MS_DIR stays index7 for 8 cycles, then returns to index4 with moving=0.
- Reload: a qualifying up-left sample (dx=-5, dy=-5) arrives on the cycle hold=1 -> MS_DIR[0], hold reloaded to 8, no centre glitch.
- Buttons: btn_in 000->001->011->010 over four samples -> btn_press=001 then 010, btn_release=001 on the fourth sample, each 1 cycle wide.
- Saturation with CNT_W=2: 5 qualifying samples -> motion_cnt sequence 1,2,3,3,3. Reset mid-MOVING -> all outputs at reset values next cycle and state UNPRIMED.
